// File: rtl/core_mem_rd_pkg.sv
// Shared types for the core memory read sequencer: FSM states, command record, default widths.
package core_mem_rd_pkg;
  localparam int CMEM_AW   = 16;
  localparam int CMD_LEN_W = 10;
  localparam int CMD_REP_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} rd_state_t;

  typedef struct packed {
    logic [CMEM_AW-1:0]   base;
    logic [CMD_LEN_W-1:0] len;
    logic [CMEM_AW-2:0]   stride;
    logic [CMD_REP_W-1:0] rpt;
  } rd_cmd_t;
endpackage

// File: rtl/core_mem_rd_agu.sv
// Address generator: strided offset with region bit held, word/pass counters and final-word flag.
// Outputs reflect the incoming command combinationally during load so word 0 can issue on the handshake.
module core_mem_rd_agu
  import core_mem_rd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  rd_cmd_t            cmd_in,
  output logic [CMEM_AW-1:0] addr,
  output logic               last
);
  rd_cmd_t              cmd_q, src_cmd;
  logic [CMEM_AW-2:0]   off_q, src_off;
  logic [CMD_LEN_W-1:0] word_q, src_word;
  logic [CMD_REP_W-1:0] pass_q, src_pass;
  logic                 word_end;

  always_comb begin
    src_cmd  = load ? cmd_in : cmd_q;
    src_off  = load ? cmd_in.base[CMEM_AW-2:0] : off_q;
    src_word = load ? '0 : word_q;
    src_pass = load ? '0 : pass_q;
    word_end = (src_word == src_cmd.len - CMD_LEN_W'(1));
    last     = word_end && (src_pass == src_cmd.rpt - CMD_REP_W'(1));
    addr     = {src_cmd.base[CMEM_AW-1], src_off};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q  <= '0;
      off_q  <= '0;
      word_q <= '0;
      pass_q <= '0;
    end else begin
      if (load) cmd_q <= cmd_in;
      if (load || step) begin
        // Pass end reloads the base offset; the add wraps inside the offset field only.
        if (step && word_end) begin
          off_q  <= src_cmd.base[CMEM_AW-2:0];
          word_q <= '0;
          pass_q <= src_pass + CMD_REP_W'(1);
        end else if (step) begin
          off_q  <= src_off + src_cmd.stride;
          word_q <= src_word + CMD_LEN_W'(1);
          pass_q <= src_pass;
        end else begin
          off_q  <= src_off;
          word_q <= src_word;
          pass_q <= src_pass;
        end
      end
    end
  end
endmodule

// File: rtl/core_mem_rd_seq.sv
// Core memory read initiator: one strided read per cycle, throttled by LBUF and same-region GBUS reads.
// Stall/abort sampled in cycle C govern cmem_ren in C+1; done follows the final read by one cycle.
module core_mem_rd_seq
  import core_mem_rd_pkg::*;
#(
  parameter int GBUS_ADDR = CMEM_AW,
  parameter int LEN_W     = CMD_LEN_W,
  parameter int REP_W     = CMD_REP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [GBUS_ADDR-1:0] cmd_base,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic [GBUS_ADDR-2:0] cmd_stride,
  input  logic [REP_W-1:0]     cmd_repeat,
  input  logic                 abort,
  input  logic                 lbuf_almost_full,
  input  logic                 gbus_ren,
  input  logic                 gbus_addr_msb,
  output logic [GBUS_ADDR-1:0] cmem_raddr,
  output logic                 cmem_ren,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);
  rd_state_t            state_q, state_d;
  rd_cmd_t              cmd_in;
  logic                 fin_q, fin_d;
  logic                 load, issue, stall, zero_cmd, aborted_d, agu_last;
  logic [GBUS_ADDR-1:0] agu_addr;

  always_comb begin
    cmd_in.base   = cmd_base;
    cmd_in.len    = cmd_len;
    cmd_in.stride = cmd_stride;
    cmd_in.rpt    = cmd_repeat;
  end

  assign zero_cmd = (cmd_len == '0) || (cmd_repeat == '0);
  // GBUS owns the shared SRAM port only when it targets the same region.
  assign stall = lbuf_almost_full || (gbus_ren && (gbus_addr_msb == agu_addr[GBUS_ADDR-1]));

  core_mem_rd_agu u_agu (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (issue),
    .cmd_in (cmd_in),
    .addr   (agu_addr),
    .last   (agu_last)
  );

  always_comb begin
    state_d   = state_q;
    fin_d     = fin_q;
    load      = 1'b0;
    issue     = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          load  = 1'b1;
          fin_d = 1'b0;
          if (zero_cmd) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            issue   = !stall;
            fin_d   = !stall && agu_last;
          end
        end
      end
      RUN: begin
        // fin_q holds RUN one extra cycle so done lines up with the last word's read data.
        if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (fin_q) begin
          state_d = DONE;
        end else begin
          issue = !stall;
          fin_d = !stall && agu_last;
        end
      end
      DONE: begin
        state_d = IDLE;
        fin_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fin_q      <= 1'b0;
      cmem_ren   <= 1'b0;
      cmem_raddr <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fin_q     <= fin_d;
      cmem_ren  <= issue;
      if (issue) cmem_raddr <= agu_addr;
      cmd_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
      aborted   <= aborted_d;
    end
  end
endmodule

// File: tb/tb_core_mem_rd_seq.sv
// Directed bench for core_mem_rd_seq: table of commands with stall/abort patterns and hand-computed results.
module tb_core_mem_rd_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_base = '0;
  logic [9:0]  cmd_len = '0;
  logic [14:0] cmd_stride = '0;
  logic [7:0]  cmd_repeat = '0;
  logic        abort = 1'b0;
  logic        lbuf_almost_full = 1'b0;
  logic        gbus_ren = 1'b0;
  logic        gbus_addr_msb = 1'b0;
  logic [15:0] cmem_raddr;
  logic        cmem_ren;
  logic        busy;
  logic        done;
  logic        aborted;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  core_mem_rd_seq dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_base         (cmd_base),
    .cmd_len          (cmd_len),
    .cmd_stride       (cmd_stride),
    .cmd_repeat       (cmd_repeat),
    .abort            (abort),
    .lbuf_almost_full (lbuf_almost_full),
    .gbus_ren         (gbus_ren),
    .gbus_addr_msb    (gbus_addr_msb),
    .cmem_raddr       (cmem_raddr),
    .cmem_ren         (cmem_ren),
    .busy             (busy),
    .done             (done),
    .aborted          (aborted)
  );

  // Masks and cycle numbers are relative to the handshake cycle T (bit k = cycle T+k).
  typedef struct packed {
    logic [15:0]      base;
    logic [9:0]       len;
    logic [14:0]      stride;
    logic [7:0]       rpt;
    logic [31:0]      lbuf_mask;
    logic [31:0]      gbus_mask;
    logic             gbus_msb;
    logic [7:0]       abort_cyc;
    logic [3:0]       exp_n;
    logic [0:7][15:0] exp_addr;
    logic [31:0]      exp_ren;
    logic [7:0]       exp_done;
    logic             exp_ab;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [15:0] base, input logic [9:0] len, input logic [14:0] stride,
                              input logic [7:0] rpt, input logic [31:0] lbuf, input logic [31:0] gbus,
                              input logic msb, input logic [7:0] abt, input logic [3:0] n,
                              input logic [0:7][15:0] addrs, input logic [31:0] ren,
                              input logic [7:0] dn, input logic ab);
    vec_t v;
    v.base = base; v.len = len; v.stride = stride; v.rpt = rpt;
    v.lbuf_mask = lbuf; v.gbus_mask = gbus; v.gbus_msb = msb; v.abort_cyc = abt;
    v.exp_n = n; v.exp_addr = addrs; v.exp_ren = ren; v.exp_done = dn; v.exp_ab = ab;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    cmd_valid = 1'b0; abort = 1'b0; lbuf_almost_full = 1'b0;
    gbus_ren = 1'b0; gbus_addr_msb = 1'b0;
    cmd_base = '0; cmd_len = '0; cmd_stride = '0; cmd_repeat = '0;
  endtask

  task automatic run_vec(input int idx);
    vec_t        v;
    logic [15:0] got[$];
    int          done_cyc;
    logic        got_ab;
    logic [31:0] ren_mask;
    v = vecs[idx];
    done_cyc = -1; got_ab = 1'b0; ren_mask = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_base = v.base; cmd_len = v.len; cmd_stride = v.stride; cmd_repeat = v.rpt;
    lbuf_almost_full = v.lbuf_mask[0]; gbus_ren = v.gbus_mask[0]; gbus_addr_msb = v.gbus_msb;
    abort = (v.abort_cyc == 8'd0);
    for (int k = 1; k < 32 && done_cyc < 0; k++) begin
      @(posedge clk); #1;
      // Scribble the command bus after the handshake; the registered command must be unaffected.
      cmd_valid = 1'b0;
      cmd_base = 16'($urandom); cmd_len = 10'($urandom); cmd_stride = 15'($urandom); cmd_repeat = 8'($urandom);
      lbuf_almost_full = v.lbuf_mask[k]; gbus_ren = v.gbus_mask[k];
      abort = (v.abort_cyc == 8'(k));
      @(negedge clk);
      if (k == 1) check($sformatf("v%0d busy@T+1", idx), {31'd0, busy}, 32'd1);
      if (cmem_ren) begin
        ren_mask[k] = 1'b1;
        got.push_back(cmem_raddr);
      end
      if (done) begin
        done_cyc = k;
        got_ab = aborted;
        check($sformatf("v%0d ready@done", idx), {31'd0, cmd_ready}, 32'd0);
      end
    end
    if (done_cyc < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL v%0d done_timeout: got no done, expected done at T+%0d", idx, v.exp_done);
    end
    check($sformatf("v%0d n_reads", idx), got.size(), {28'd0, v.exp_n});
    for (int i = 0; i < int'(v.exp_n); i++)
      check($sformatf("v%0d addr%0d", idx, i), (i < got.size()) ? {16'd0, got[i]} : 32'hDEAD_BEEF,
            {16'd0, v.exp_addr[i]});
    check($sformatf("v%0d ren_cycles", idx), ren_mask, v.exp_ren);
    check($sformatf("v%0d done_cycle", idx), done_cyc, {24'd0, v.exp_done});
    check($sformatf("v%0d aborted", idx), {31'd0, got_ab}, {31'd0, v.exp_ab});
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check($sformatf("v%0d ready_after", idx), {29'd0, cmd_ready, busy, done}, 32'b100);
  endtask

  initial begin
    vecs[0]  = mk(16'h0010, 10'd4, 15'd1, 8'd1, 32'h0, 32'h0, 1'b0, 8'hFF, 4'd4,
                  {16'h0010, 16'h0011, 16'h0012, 16'h0013, 64'h0}, 32'h1E, 8'd5, 1'b0);
    vecs[1]  = mk(16'h8000, 10'd3, 15'd4, 8'd2, 32'h0, 32'h0, 1'b0, 8'hFF, 4'd6,
                  {16'h8000, 16'h8004, 16'h8008, 16'h8000, 16'h8004, 16'h8008, 32'h0}, 32'h7E, 8'd7, 1'b0);
    vecs[2]  = mk(16'h0010, 10'd4, 15'd1, 8'd1, 32'hE, 32'h0, 1'b0, 8'hFF, 4'd4,
                  {16'h0010, 16'h0011, 16'h0012, 16'h0013, 64'h0}, 32'hE2, 8'd8, 1'b0);
    vecs[3]  = mk(16'h8000, 10'd4, 15'd1, 8'd1, 32'h0, 32'h6, 1'b1, 8'hFF, 4'd4,
                  {16'h8000, 16'h8001, 16'h8002, 16'h8003, 64'h0}, 32'h72, 8'd7, 1'b0);
    vecs[4]  = mk(16'h8000, 10'd4, 15'd1, 8'd1, 32'h0, 32'h6, 1'b0, 8'hFF, 4'd4,
                  {16'h8000, 16'h8001, 16'h8002, 16'h8003, 64'h0}, 32'h1E, 8'd5, 1'b0);
    vecs[5]  = mk(16'h7FFE, 10'd4, 15'd1, 8'd1, 32'h0, 32'h0, 1'b0, 8'hFF, 4'd4,
                  {16'h7FFE, 16'h7FFF, 16'h0000, 16'h0001, 64'h0}, 32'h1E, 8'd5, 1'b0);
    vecs[6]  = mk(16'h1234, 10'd0, 15'd1, 8'd3, 32'h0, 32'h0, 1'b0, 8'hFF, 4'd0,
                  128'h0, 32'h0, 8'd1, 1'b0);
    vecs[7]  = mk(16'h1234, 10'd5, 15'd1, 8'd0, 32'h0, 32'h0, 1'b0, 8'hFF, 4'd0,
                  128'h0, 32'h0, 8'd1, 1'b0);
    vecs[8]  = mk(16'h0100, 10'd8, 15'd2, 8'd1, 32'h0, 32'h0, 1'b0, 8'd2, 4'd2,
                  {16'h0100, 16'h0102, 96'h0}, 32'h6, 8'd3, 1'b1);
    vecs[9]  = mk(16'h0020, 10'd2, 15'd3, 8'd1, 32'h0, 32'h0, 1'b0, 8'd0, 4'd2,
                  {16'h0020, 16'h0023, 96'h0}, 32'h6, 8'd3, 1'b0);
    vecs[10] = mk(16'hFFF0, 10'd3, 15'h0010, 8'd1, 32'h0, 32'h0, 1'b0, 8'hFF, 4'd3,
                  {16'hFFF0, 16'h8000, 16'h8010, 80'h0}, 32'hE, 8'd4, 1'b0);
    vecs[11] = mk(16'h0300, 10'd1, 15'd1, 8'd1, 32'h1, 32'h0, 1'b0, 8'hFF, 4'd1,
                  {16'h0300, 112'h0}, 32'h4, 8'd3, 1'b0);
    vecs[12] = mk(16'h0040, 10'd2, 15'd1, 8'd1, 32'h0, 32'h0, 1'b0, 8'd1, 4'd1,
                  {16'h0040, 112'h0}, 32'h2, 8'd2, 1'b1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {12'd0, cmem_raddr, cmd_ready, cmem_ren, busy, done, aborted}, {12'd0, 16'h0000, 5'b10000});
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i);

    // Reset in the middle of a long command: outputs return to reset values and stay quiet.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_base = 16'h0200; cmd_len = 10'd8; cmd_stride = 15'd1; cmd_repeat = 8'd1;
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrun_before_rst", {30'd0, cmem_ren, busy}, 32'b11);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrun_reset_outputs", {12'd0, cmem_raddr, cmd_ready, cmem_ren, busy, done, aborted}, {12'd0, 16'h0000, 5'b10000});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_quiet%0d", k), {29'd0, cmem_ren, done, busy}, 32'd0);
    end
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/core_mem_rd_seq.md
# core_mem_rd_seq

Read-side initiator for the core memory's MAC channel. It accepts a strided, repeatable read command and drives `cmem_raddr`/`cmem_ren` one word per cycle into WMEM or the KV cache; the region is selected by address MSB. Issue is throttled by LBUF back-pressure (`lbuf_almost_full`) and by GBUS reads that would steal the same SRAM port. It sits between the core controller and the core memory block, and feeds the CLINK/LBUF path.

## Interface
Parameters:
- `GBUS_ADDR`, 16: cmem/GBUS address width. MSB = region (0 WMEM, 1 KV cache).
- `LEN_W`, 10: width of the words-per-pass field.
- `REP_W`, 8: width of the pass-repeat field.

Ports:
- `clk`  in  1: single clock. One clock `clk`; reset `rst` is synchronous and active-high.
- `rst`  in  1: synchronous active-high reset.
- `cmd_valid`  in  1: command offer.
- `cmd_ready`  out  1: high only in IDLE.
- `cmd_base`  in  GBUS_ADDR: start address, including the region MSB.
- `cmd_len`  in  LEN_W: words per pass.
- `cmd_stride`  in  GBUS_ADDR-1: address increment per word.
- `cmd_repeat`  in  REP_W: number of passes.
- `abort`  in  1: stop the current command.
- `lbuf_almost_full`  in  1: LBUF back-pressure.
- `gbus_ren`  in  1: GBUS read in progress.
- `gbus_addr_msb`  in  1: region of that GBUS read.
- `cmem_raddr`  out  GBUS_ADDR: read address.
- `cmem_ren`  out  1: read strobe.
- `busy`  out  1: state not IDLE.
- `done`  out  1: one-cycle completion pulse.
- `aborted`  out  1: qualifies `done`; valid only while `done` is high.

## Operation
- States:
  - IDLE: `cmd_ready`=1.
  - RUN: issuing reads.
  - DONE: one cycle; `done`=1.
- Transitions:
  - IDLE→RUN on handshake when `cmd_len`≠0 and `cmd_repeat`≠0.
  - IDLE→DONE on handshake when either field is 0; no reads are issued.
  - RUN→DONE after the final read is issued, or on `abort`.
  - DONE→IDLE unconditionally.
- Sequence: for pass r in 0..repeat-1, for word i in 0..len-1, read address = {base[MSB], (base[MSB-1:0] + i·stride) mod 2^(GBUS_ADDR-1)}.
  - The region bit is held from `cmd_base` for the whole command; only the offset wraps.
  - At the end of each pass the offset reloads to the base. No carry into the MSB.
- Stall: no read is issued in a cycle if `lbuf_almost_full`, or if `gbus_ren` && `gbus_addr_msb`==region. The core memory gives GBUS reads priority on the shared address.
  - A stalled word is reissued later with the same address.
  - No word is skipped or duplicated.
- Abort: in RUN/DONE it ends issue; `done`=1 with `aborted`=1. Words already issued still return. In IDLE, `abort` is ignored.
- Command fields are registered at the handshake; later changes on the `cmd_*` inputs have no effect.

## Timing
- All outputs are registered.
- Reset values: `cmd_ready`=1; `cmem_ren`=0; `cmem_raddr`=0; `busy`=0; `done`=0; `aborted`=0. All counters cleared.
- `rst` mid-command discards the command and returns to IDLE on the next edge; no `done` pulse.
- Stall and abort inputs sampled in cycle C govern `cmem_ren` in cycle C+1. The LBUF's ALERT_DEPTH=3 margin covers this one-cycle lag plus the one-cycle read latency.
- Handshake in cycle T gives:
  - the first `cmem_ren` in T+1, assuming no stall;
  - `busy` high from T+1.
- Final read in cycle N gives:
  - `done` in N+1, aligned with the core memory's `cmem_rvalid` for that word;
  - `cmd_ready` high again in N+2.
- Zero-length command accepted in T: `done` in T+1, IDLE in T+2.
- Throughput is one word per cycle when unstalled.
- If `abort` and the final issue decision fall in the same cycle, abort wins: no read is issued and `aborted`=1.

## Structure
- Shared package `core_mem_rd_pkg`:
  - state enum {IDLE, RUN, DONE};
  - command struct {base, len, stride, repeat};
  - the LEN_W/REP_W defaults.
- Sub-module `core_mem_rd_agu` holds the offset register, the word and pass counters, the wrap add, and the `last` flag. The top level holds the FSM, stall logic and output registers.

## Test plan
- Base 0x0010, len 4, stride 1, repeat 1, no stall → `cmem_raddr` 0x0010..0x0013 in T+1..T+4; `done` at T+5; `cmd_ready` at T+6.
- Base 0x8000, len 3, stride 4, repeat 2 → 0x8000, 0x8004, 0x8008, 0x8000, 0x8004, 0x8008 back-to-back; `done` once.
- Same as the first case with `lbuf_almost_full` high in T+1..T+3 → `cmem_ren` low in T+2..T+4; all four addresses still appear once, in order.
- Cache command with `gbus_ren`=1 and `gbus_addr_msb`=1 for 2 cycles → 2-cycle issue gap. Repeat with `gbus_addr_msb`=0 → no gap.
- Base 0x7FFE, len 4, stride 1 → 0x7FFE, 0x7FFF, 0x0000, 0x0001 (MSB stays 0).
- Zero-length command → no `cmem_ren`, `done` at T+1.
- Abort after 2 of 8 reads → exactly 2 strobes; `done`=1 and `aborted`=1 one cycle after abort.
- `rst` mid-run → all outputs at reset values the next cycle.
